// File: rtl/rng_pkg.sv
// Shared state type, LFSR tap table and parameter legality checks for rng_seq_gen.
package rng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Maximal-length Galois masks (right-shifting form); zero marks an unsupported width.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic bit params_ok(input int unsigned lfsr_w,
                                     input int unsigned digit_w,
                                     input int unsigned max_val,
                                     input int unsigned seq_len,
                                     input logic [31:0] seed);
        logic [31:0] mask;
        mask = (lfsr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << lfsr_w) - 32'd1);
        if (lfsr_taps(lfsr_w) == 32'd0)            return 1'b0;
        if ((digit_w == 0) || (digit_w > lfsr_w))  return 1'b0;
        if (64'(max_val) >= (64'd1 << digit_w))    return 1'b0;
        if (seq_len < 2)                           return 1'b0;
        if ((seed & mask) == 32'd0)                return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/rng_seq_gen_if.sv
// Control, stream and read-port signals between rng_seq_gen and its neighbours.
interface rng_seq_gen_if #(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned ADDR_W  = 3
);
    logic               button_pulse;
    logic               auth_bit;
    logic               out_ready;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DIGIT_W-1:0] random_num;
    logic               enable;
    logic               busy;
    logic               seq_done;
    logic [DIGIT_W-1:0] rd_data;

    modport master (
        input  button_pulse, auth_bit, out_ready, rd_addr,
        output random_num, enable, busy, seq_done, rd_data
    );

    modport slave (
        output button_pulse, auth_bit, out_ready, rd_addr,
        input  random_num, enable, busy, seq_done, rd_data
    );
endinterface

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with reload of SEED if it ever reaches all zeros.
module lfsr_core
    import rng_pkg::*;
#(
    parameter int unsigned       LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(32'h0000_ACE1),
    parameter int unsigned       OUT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] digit
);
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin : step
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) lfsr_d = lfsr_d ^ TAPS;
        if (lfsr_q == '0) lfsr_d = SEED;
    end

    always_ff @(posedge clk or negedge rst) begin : regs
        if (!rst) lfsr_q <= SEED;
        else      lfsr_q <= lfsr_d;
    end

    assign digit = lfsr_q[OUT_W-1:0];
endmodule

// File: rtl/rng_seq_gen.sv
// Fills a buffer with range-limited random digits, streams it out, and serves random reads.
// Optional: define RNG_NO_REPEAT_EN to forbid equal adjacent digits within a sequence.
module rng_seq_gen
    import rng_pkg::*;
#(
    parameter int unsigned LFSR_W  = 16,
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned MAX_VAL = 9,
    parameter int unsigned SEQ_LEN = 8,
    parameter logic [31:0] SEED    = 32'h0000_ACE1
) (
    input logic           clk,
    input logic           rst,
    rng_seq_gen_if.master bus
);
    localparam int unsigned ADDR_W = $clog2(SEQ_LEN);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SEQ_LEN - 1);

    if (!params_ok(LFSR_W, DIGIT_W, MAX_VAL, SEQ_LEN, SEED)) begin : g_param_error
        $error("rng_seq_gen: illegal parameter set");
    end

    logic [DIGIT_W-1:0] lfsr_digit;

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .SEED   (LFSR_W'(SEED)),
        .OUT_W  (DIGIT_W)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .digit (lfsr_digit)
    );

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    // Entries at or above SEQ_LEN are never written, so out-of-range reads return 0.
    logic [DIGIT_W-1:0] buffer_q [DEPTH];
    logic [DIGIT_W-1:0] buffer_d [DEPTH];
    logic [DIGIT_W-1:0] random_num_q, random_num_d;
    logic               enable_q, enable_d;
    logic               busy_q, busy_d;
    logic               seq_done_q, seq_done_d;
    logic [DIGIT_W-1:0] rd_data_q, rd_data_d;
    logic [DIGIT_W-1:0] cand;
    logic               accept;

    always_comb begin : next_state
        state_d      = state_q;
        idx_d        = idx_q;
        buffer_d     = buffer_q;
        random_num_d = random_num_q;
        cand         = lfsr_digit;
        accept       = (cand <= DIGIT_W'(MAX_VAL));
`ifdef RNG_NO_REPEAT_EN
        if ((idx_q != '0) && (cand == buffer_q[idx_q - ADDR_W'(1)])) accept = 1'b0;
`endif
        if (!bus.auth_bit) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.button_pulse) begin
                        state_d = ST_FILL;
                        idx_d   = '0;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        buffer_d[idx_q] = cand;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_PLAY;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + ADDR_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    if (enable_q && bus.out_ready) begin
                        if (idx_q == LAST_IDX) state_d = ST_DONE;
                        else                   idx_d   = idx_q + ADDR_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs follow the next state so they are registered alongside it.
        busy_d     = (state_d == ST_FILL) || (state_d == ST_PLAY);
        enable_d   = (state_d == ST_PLAY);
        seq_done_d = (state_d == ST_DONE);
        if (enable_d) random_num_d = buffer_q[idx_d];
        rd_data_d  = buffer_q[bus.rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin : regs
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            buffer_q     <= '{default: '0};
            random_num_q <= '0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            seq_done_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            buffer_q     <= buffer_d;
            random_num_q <= random_num_d;
            enable_q     <= enable_d;
            busy_q       <= busy_d;
            seq_done_q   <= seq_done_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign bus.random_num = random_num_q;
    assign bus.enable     = enable_q;
    assign bus.busy       = busy_q;
    assign bus.seq_done   = seq_done_q;
    assign bus.rd_data    = rd_data_q;
endmodule

// File: tb/tb_rng_seq_gen.sv
// Scoreboard bench for rng_seq_gen: a reference LFSR predicts each sequence, a monitor checks every beat.
module tb_rng_seq_gen;
    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned DIGIT_W = 4;
    localparam int          MAX_VAL = 9;
    localparam int          SEQ_LEN = 8;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam logic [15:0] TAPS    = 16'hB400;
`ifdef RNG_NO_REPEAT_EN
    localparam bit NO_REPEAT = 1'b1;
`else
    localparam bit NO_REPEAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rng_seq_gen_if #(.DIGIT_W(DIGIT_W), .ADDR_W(3)) bus ();

    rng_seq_gen #(
        .LFSR_W  (LFSR_W),
        .DIGIT_W (DIGIT_W),
        .MAX_VAL (MAX_VAL),
        .SEQ_LEN (SEQ_LEN),
        .SEED    (32'(SEED))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int exp_q[$];
    int exp_seq[SEQ_LEN];
    int seen[SEQ_LEN];
    int beats = 0;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v == 16'd0) return SEED;
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    // Reference LFSR runs every cycle in lock-step with the design.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Predict the sequence that a start accepted at the coming edge will produce.
    task automatic gen_expected();
        logic [15:0] v;
        int n, prev, cand, guard;
        v = lfsr_step(m_lfsr);
        n = 0; prev = -1; guard = 0;
        while (n < SEQ_LEN && guard < 100000) begin
            cand = int'(v[DIGIT_W-1:0]);
            if (cand <= MAX_VAL && !(NO_REPEAT && n > 0 && cand == prev)) begin
                exp_seq[n] = cand;
                exp_q.push_back(cand);
                prev = cand;
                n++;
            end
            v = lfsr_step(v);
            guard++;
        end
    endtask

    // Called at posedge+1; the pulse is sampled at the following edge.
    task automatic start_seq();
        exp_q.delete();
        gen_expected();
        beats = 0;
        bus.button_pulse = 1'b1;
        @(posedge clk); #1;
        bus.button_pulse = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (beats < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("beats_reached", beats >= n, 1);
    endtask

    task automatic finish_seq(input bit rnd_ready);
        int k = 0;
        while (!bus.seq_done && k < 600) begin
            bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            k++;
        end
        bus.out_ready = 1'b1;
        check("seq_done_reached", bus.seq_done, 1);
        check("beat_count", beats, SEQ_LEN);
        check("scoreboard_drained", exp_q.size(), 0);
        check("busy_in_done", bus.busy, 0);
        check("enable_in_done", bus.enable, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_random_num", bus.random_num, 0);
        check("rst_enable", bus.enable, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_seq_done", bus.seq_done, 0);
        check("rst_rd_data", bus.rd_data, 0);
    endtask

    // Monitor: every accepted beat is popped from the scoreboard and compared.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst && bus.enable && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_digit", bus.random_num, e);
                end
                check("beat_range", bus.random_num <= MAX_VAL, 1);
                if (NO_REPEAT && beats > 0 && beats <= SEQ_LEN)
                    check("beat_no_repeat", bus.random_num != seen[beats-1], 1);
                if (beats < SEQ_LEN) seen[beats] = int'(bus.random_num);
                beats++;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int held_beats;
        rst = 1'b0;
        bus.button_pulse = 1'b0;
        bus.auth_bit     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.rd_addr      = 3'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b1;
        check("lfsr_seed", dut.u_lfsr.lfsr_q, SEED);

        // Unauthenticated press must be ignored.
        @(posedge clk); #1;
        bus.button_pulse = 1'b1;
        @(posedge clk); #1;
        bus.button_pulse = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("gate_busy", bus.busy, 0);
            check("gate_enable", bus.enable, 0);
        end

        // Plain fill and stream with a ready consumer.
        @(posedge clk); #1;
        bus.auth_bit  = 1'b1;
        bus.out_ready = 1'b1;
        start_seq();
        @(negedge clk);
        check("busy_after_pulse", bus.busy, 1);
        finish_seq(1'b0);

        // Restart from DONE, press during FILL, then a backpressure stall.
        start_seq();
        @(negedge clk);
        check("seq_done_clears", bus.seq_done, 0);
        @(posedge clk); #1;
        bus.button_pulse = 1'b1;
        @(posedge clk); #1;
        bus.button_pulse = 1'b0;
        wait_beats(2, 300);
        bus.out_ready = 1'b0;
        held_beats = beats;
        repeat (5) begin
            @(negedge clk);
            check("hold_enable", bus.enable, 1);
            check("hold_digit", bus.random_num, exp_seq[2]);
            check("hold_beats", beats, held_beats);
        end
        @(posedge clk); #1;
        finish_seq(1'b1);

        // Abort after three beats, then read the buffer back.
        start_seq();
        wait_beats(3, 300);
        bus.auth_bit  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_enable", bus.enable, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_seq_done", bus.seq_done, 0);
        check("abort_beats", beats, 3);
        exp_q.delete();
        for (int a = 0; a < SEQ_LEN; a++) begin
            @(posedge clk); #1;
            bus.rd_addr = 3'(a);
            @(posedge clk);
            @(negedge clk);
            check("readback", bus.rd_data, exp_seq[a]);
            if (a < 3) check("readback_vs_beat", bus.rd_data, seen[a]);
        end

        // Many sequences with random gaps and random consumer readiness.
        @(posedge clk); #1;
        bus.auth_bit  = 1'b1;
        bus.out_ready = 1'b1;
        for (int s = 0; s < 50; s++) begin
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk); #1;
            end
            start_seq();
            finish_seq(1'b1);
        end

        // Asynchronous reset in the middle of streaming.
        start_seq();
        wait_beats(2, 300);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        check("lfsr_seed_after_reset", dut.u_lfsr.lfsr_q, SEED);
        @(negedge clk);
        check("buffer_cleared", bus.rd_data, 0);
        check("idle_after_reset", bus.busy, 0);
        @(posedge clk); #1;
        start_seq();
        finish_seq(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
